// File: rtl/instruction_fetch_stage.sv
// IF stage: owns the PC and the IF/ID register, with stall hold and
// branch/jump redirect with flush.
module instruction_fetch_stage #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int          IMEM_BYTES = 64
) (
  input  logic        Clk,
  input  logic        Rst,
  input  logic        Stall,
  input  logic        BranchTaken,
  input  logic [31:0] BranchTarget,
  input  logic        JumpTaken,
  input  logic [31:0] JumpTarget,
  input  logic [31:0] ImemData,
  output logic [31:0] ImemAddr,
  output logic [31:0] PC,
  output logic [31:0] IF_ID_Instr,
  output logic [31:0] IF_ID_PCPlus4,
  output logic        IF_ID_Valid,
  output logic [31:0] FetchCount,
  output logic        MisalignErr
);

  localparam int AW = $clog2(IMEM_BYTES);

  logic [31:0] pc_q, pc_d;
  logic [31:0] instr_q, instr_d;
  logic [31:0] pcp4_q, pcp4_d;
  logic        valid_q, valid_d;
  logic [31:0] cnt_q, cnt_d;
  logic        mis_q, mis_d;

  logic        redir;
  logic [31:0] tgt;
  logic [31:0] pc_inc;

  assign redir  = BranchTaken | JumpTaken;
  assign tgt    = BranchTaken ? BranchTarget : JumpTarget;
  assign pc_inc = pc_q + 32'd4;

  always_comb begin
    pc_d    = pc_q;
    instr_d = instr_q;
    pcp4_d  = pcp4_q;
    valid_d = valid_q;
    cnt_d   = cnt_q;
    mis_d   = mis_q;
    if (redir) begin
      pc_d    = {tgt[31:2], 2'b00};
      instr_d = 32'h0;
      pcp4_d  = 32'h0;
      valid_d = 1'b0;
      if (tgt[1:0] != 2'b00) mis_d = 1'b1;
    end else if (!Stall) begin
      pc_d    = pc_inc;
      instr_d = ImemData;
      pcp4_d  = pc_inc;
      valid_d = 1'b1;
      cnt_d   = cnt_q + 32'd1;
    end
  end

  always_ff @(posedge Clk) begin
    if (Rst) begin
      pc_q    <= RESET_PC;
      instr_q <= 32'h0;
      pcp4_q  <= 32'h0;
      valid_q <= 1'b0;
      cnt_q   <= 32'h0;
      mis_q   <= 1'b0;
    end else begin
      pc_q    <= pc_d;
      instr_q <= instr_d;
      pcp4_q  <= pcp4_d;
      valid_q <= valid_d;
      cnt_q   <= cnt_d;
      mis_q   <= mis_d;
    end
  end

  // Fetch wraps inside the memory; PC itself keeps all 32 bits.
  assign ImemAddr      = {{(32-AW){1'b0}}, pc_q[AW-1:0]};
  assign PC            = pc_q;
  assign IF_ID_Instr   = instr_q;
  assign IF_ID_PCPlus4 = pcp4_q;
  assign IF_ID_Valid   = valid_q;
  assign FetchCount    = cnt_q;
  assign MisalignErr   = mis_q;

endmodule

// File: tb/tb_instruction_fetch_stage.sv
// Randomized bench for instruction_fetch_stage against a behavioural
// model, plus directed scenarios with literal expectations.
module tb_instruction_fetch_stage;

  logic        Clk = 1'b0;
  logic        Rst = 1'b0;
  logic        Stall = 1'b0;
  logic        BranchTaken = 1'b0;
  logic [31:0] BranchTarget = 32'h0;
  logic        JumpTaken = 1'b0;
  logic [31:0] JumpTarget = 32'h0;
  logic [31:0] ImemData;
  logic [31:0] ImemAddr;
  logic [31:0] PC;
  logic [31:0] IF_ID_Instr;
  logic [31:0] IF_ID_PCPlus4;
  logic        IF_ID_Valid;
  logic [31:0] FetchCount;
  logic        MisalignErr;

  int checks = 0;
  int failures = 0;
  bit chk_en = 1'b0;

  logic [31:0] mem [16];

  logic [31:0] m_pc = 32'h0;
  logic [31:0] m_instr = 32'h0;
  logic [31:0] m_pcp4 = 32'h0;
  logic        m_valid = 1'b0;
  logic [31:0] m_cnt = 32'h0;
  logic        m_mis = 1'b0;

  instruction_fetch_stage dut (
    .Clk(Clk),
    .Rst(Rst),
    .Stall(Stall),
    .BranchTaken(BranchTaken),
    .BranchTarget(BranchTarget),
    .JumpTaken(JumpTaken),
    .JumpTarget(JumpTarget),
    .ImemData(ImemData),
    .ImemAddr(ImemAddr),
    .PC(PC),
    .IF_ID_Instr(IF_ID_Instr),
    .IF_ID_PCPlus4(IF_ID_PCPlus4),
    .IF_ID_Valid(IF_ID_Valid),
    .FetchCount(FetchCount),
    .MisalignErr(MisalignErr)
  );

  always #5 Clk = ~Clk;

  assign ImemData = mem[ImemAddr[5:2]];

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h t=%0t", nm, act, exp, $time);
    end
  endtask

  // Reference: apply the per-edge priority rules directly.
  always @(posedge Clk) begin
    logic [31:0] t;
    if (Rst) begin
      m_pc = 32'h0; m_instr = 32'h0; m_pcp4 = 32'h0;
      m_valid = 1'b0; m_cnt = 32'h0; m_mis = 1'b0;
    end else if (BranchTaken || JumpTaken) begin
      t = BranchTaken ? BranchTarget : JumpTarget;
      if (t % 4 != 0) m_mis = 1'b1;
      m_pc = t - (t % 4);
      m_instr = 32'h0; m_pcp4 = 32'h0; m_valid = 1'b0;
    end else if (!Stall) begin
      m_instr = mem[(m_pc % 64) / 4];
      m_pc = m_pc + 4;
      m_pcp4 = m_pc;
      m_valid = 1'b1;
      m_cnt = m_cnt + 1;
    end
  end

  always @(negedge Clk) begin
    if (chk_en) begin
      chk("pc", PC, m_pc);
      chk("imem_addr", ImemAddr, m_pc % 64);
      chk("instr", IF_ID_Instr, m_instr);
      chk("pcplus4", IF_ID_PCPlus4, m_pcp4);
      chk("valid", {31'b0, IF_ID_Valid}, {31'b0, m_valid});
      chk("fetch_count", FetchCount, m_cnt);
      chk("misalign", {31'b0, MisalignErr}, {31'b0, m_mis});
    end
  end

  task automatic cyc(input bit r, input bit s, input bit b,
                     input logic [31:0] bt, input bit j,
                     input logic [31:0] jt);
    Rst = r; Stall = s; BranchTaken = b; BranchTarget = bt;
    JumpTaken = j; JumpTarget = jt;
    @(posedge Clk);
    #1;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) cyc(0, 0, 0, 0, 0, 0);
  endtask

  initial begin
    for (int i = 0; i < 16; i++) mem[i] = $urandom;
    mem[0] = 32'h2008_0005;
    mem[1] = 32'h2009_0003;
    mem[2] = 32'h0109_5020;
    mem[3] = 32'hAC0A_0000;
    mem[9] = 32'h8C0B_0004;
    mem[15] = 32'h1234_5678;

    // T1
    cyc(1, 0, 0, 0, 0, 0);
    chk_en = 1'b1;
    chk("rst_pc", PC, 32'h0);
    chk("rst_valid", {31'b0, IF_ID_Valid}, 32'h0);
    chk("rst_cnt", FetchCount, 32'h0);
    run(4);
    chk("t1_pc", PC, 32'h10);
    chk("t1_instr", IF_ID_Instr, 32'hAC0A_0000);
    chk("t1_pcp4", IF_ID_PCPlus4, 32'h10);
    chk("t1_valid", {31'b0, IF_ID_Valid}, 32'h1);
    chk("t1_cnt", FetchCount, 32'd4);

    // T2
    cyc(1, 0, 0, 0, 0, 0);
    run(2);
    for (int i = 0; i < 3; i++) cyc(0, 1, 0, 0, 0, 0);
    chk("t2_pc", PC, 32'h8);
    chk("t2_addr", ImemAddr, 32'h8);
    chk("t2_instr", IF_ID_Instr, 32'h2009_0003);
    chk("t2_cnt", FetchCount, 32'd2);

    // T3
    run(1);
    cyc(0, 0, 1, 32'h24, 1, 32'h30);
    chk("t3_pc", PC, 32'h24);
    chk("t3_valid", {31'b0, IF_ID_Valid}, 32'h0);
    chk("t3_instr", IF_ID_Instr, 32'h0);
    run(1);
    chk("t3_instr2", IF_ID_Instr, 32'h8C0B_0004);
    chk("t3_pcp4", IF_ID_PCPlus4, 32'h28);

    // T4
    cyc(0, 1, 0, 0, 1, 32'h42);
    chk("t4_pc", PC, 32'h40);
    chk("t4_mis", {31'b0, MisalignErr}, 32'h1);
    chk("t4_valid", {31'b0, IF_ID_Valid}, 32'h0);
    chk("t5_wrap_addr", ImemAddr, 32'h0);
    run(10);
    chk("t4_mis_sticky", {31'b0, MisalignErr}, 32'h1);
    chk("t4_pc2", PC, 32'h68);

    // T5: reset during stall and redirect
    cyc(0, 1, 0, 0, 0, 0);
    cyc(1, 1, 1, 32'h55, 0, 0);
    chk("t5_pc", PC, 32'h0);
    chk("t5_mis", {31'b0, MisalignErr}, 32'h0);
    chk("t5_cnt", FetchCount, 32'h0);
    chk("t5_pcp4", IF_ID_PCPlus4, 32'h0);
    run(1);
    chk("t5_instr", IF_ID_Instr, 32'h2008_0005);

    // PC wraps modulo 2^32
    cyc(0, 0, 1, 32'hFFFF_FFFC, 0, 0);
    run(1);
    chk("pcwrap_pc", PC, 32'h0);
    chk("pcwrap_pcp4", IF_ID_PCPlus4, 32'h0);
    chk("pcwrap_instr", IF_ID_Instr, 32'h1234_5678);

    // Randomized phase
    for (int i = 0; i < 3000; i++) begin
      bit r, s, b, j;
      logic [31:0] bt, jt;
      r = ($urandom_range(0, 63) == 0);
      s = ($urandom_range(0, 3) == 0);
      b = ($urandom_range(0, 9) == 0);
      j = ($urandom_range(0, 9) == 0);
      bt = $urandom;
      jt = $urandom;
      if ($urandom_range(0, 3) != 0) bt[1:0] = 2'b00;
      if ($urandom_range(0, 3) != 0) jt[1:0] = 2'b00;
      if ($urandom_range(0, 1) == 0) bt[31:6] = '0;
      if ($urandom_range(0, 1) == 0) jt[31:6] = '0;
      cyc(r, s, b, bt, j, jt);
    end

    @(negedge Clk);
    chk_en = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
